i2c_stream_decoder: RTL and testbench

Parametrised I2C bus-monitor decoder: it samples SCL and SDA through a synchroniser and a glitch filter, and decodes START, repeated START, STOP, address and data bytes. Decoded events are buffered in an internal event FIFO, which absorbs back-pressure from the downstream character FIFO and UART path. An optional address filter passes only frames addressed to one target, and the block renders every frame as an ASCII line.

---
 rtl/i2c_stream_decoder.sv | 247 ++++++++++++++++++++++++
 tb/tb_i2c_stream_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_stream_decoder.sv
// I2C bus monitor: filters SCL/SDA, decodes START/Sr/STOP/address/data into an
// event FIFO, and renders each event as ASCII characters for a downstream FIFO.
module i2c_stream_decoder #(
    parameter int         FILT_LEN      = 3,
    parameter int         EVT_DEPTH     = 16,
    parameter int         ADDR_MATCH_EN = 0,
    parameter logic [6:0] MATCH_ADDR    = 7'h50
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_i2c_scl,
    input  logic       i_i2c_sda,
    input  logic       i_wfull,
    input  logic       i_clr_ovf,
    output logic       o_wen,
    output logic [7:0] o_wdata,
    output logic       o_overflow,
    output logic       o_busy
);
    // state  | meaning
    // C_IDLE | bus free, waiting for START
    // C_ADDR | shifting the address byte
    // C_DATA | address accepted, shifting data bytes
    // C_SKIP | address rejected by the filter, waiting for START/STOP
    // F_IDLE | formatter has no event loaded
    // F_EMIT | formatter emitting characters of the loaded event
    typedef enum logic [1:0] {C_IDLE, C_ADDR, C_DATA, C_SKIP} cap_state_t;
    typedef enum logic {F_IDLE, F_EMIT} fmt_state_t;

    localparam int         AW        = $clog2(EVT_DEPTH);
    localparam logic [3:0] FILT_LOAD = 4'(FILT_LEN);
    localparam logic [1:0] EV_ADDR_S = 2'd0, EV_ADDR_SR = 2'd1, EV_DATA = 2'd2, EV_STOP = 2'd3;

    // index 1 = SCL, index 0 = SDA
    logic [1:0] raw, sync_a, sync_b, filt, filt_q;
    logic [3:0] fcnt [2];
    assign raw = {i_i2c_scl, i_i2c_sda};

    // filter counters count down the remaining differing samples before a change
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
            filt   <= 2'b11;
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt[i] <= FILT_LOAD;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    fcnt[i] <= FILT_LOAD;
                end else if (fcnt[i] == 4'd1) begin
                    filt[i] <= sync_b[i];
                    fcnt[i] <= FILT_LOAD;
                end else begin
                    fcnt[i] <= fcnt[i] - 4'd1;
                end
            end
        end
    end

    logic start_det, stop_det, bit_det;
    assign start_det = filt_q[1] & filt[1] & filt_q[0] & ~filt[0];
    assign stop_det  = filt_q[1] & filt[1] & ~filt_q[0] & filt[0];
    assign bit_det   = ~filt_q[1] & filt[1];

    cap_state_t  cap_state, cap_next;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic        kind_sr, kind_sr_n, push_q, push_n;
    logic [10:0] push_data_q, push_data_n;

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            cap_state   <= C_IDLE;
            bit_cnt     <= 4'd0;
            shreg       <= 8'h00;
            kind_sr     <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= 11'h000;
        end else begin
            cap_state   <= cap_next;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            kind_sr     <= kind_sr_n;
            push_q      <= push_n;
            push_data_q <= push_data_n;
        end
    end

    always_comb begin
        cap_next    = cap_state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        kind_sr_n   = kind_sr;
        push_n      = 1'b0;
        push_data_n = push_data_q;
        if (start_det) begin
            cap_next  = C_ADDR;
            kind_sr_n = (cap_state != C_IDLE);
            bit_cnt_n = 4'd0;
        end else if (stop_det) begin
            if (cap_state == C_DATA) begin
                push_n      = 1'b1;
                push_data_n = {EV_STOP, 8'h00, 1'b0};
            end
            cap_next = C_IDLE;
        end else if (bit_det && (cap_state == C_ADDR || cap_state == C_DATA)) begin
            if (bit_cnt == 4'd8) begin
                bit_cnt_n = 4'd0;
                if (cap_state == C_DATA) begin
                    push_n      = 1'b1;
                    push_data_n = {EV_DATA, shreg, filt[0]};
                end else if (ADDR_MATCH_EN != 0 && shreg[7:1] != MATCH_ADDR) begin
                    cap_next = C_SKIP;
                end else begin
                    push_n      = 1'b1;
                    push_data_n = {(kind_sr ? EV_ADDR_SR : EV_ADDR_S), shreg, filt[0]};
                    cap_next    = C_DATA;
                end
            end else begin
                shreg_n   = {shreg[6:0], filt[0]};
                bit_cnt_n = bit_cnt + 4'd1;
            end
        end
    end

    logic [10:0] mem [EVT_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_ok;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // a pop in the same cycle frees the slot the push needs
    assign push_ok = push_q && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data_q;
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_q && !push_ok) o_overflow <= 1'b1;
            else if (i_clr_ovf)     o_overflow <= 1'b0;
        end
    end

    fmt_state_t  fmt_state, fmt_next;
    logic [10:0] evt, evt_n;
    logic [3:0]  idx, idx_n, ev_len, j;
    logic [1:0]  ev_type;
    logic [7:0]  ev_byte, ch;
    logic        ev_ack, last;
    assign ev_type = evt[10:9];
    assign ev_byte = evt[8:1];
    assign ev_ack  = evt[0];

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            fmt_state <= F_IDLE;
            evt       <= 11'h000;
            idx       <= 4'd0;
        end else begin
            fmt_state <= fmt_next;
            evt       <= evt_n;
            idx       <= idx_n;
        end
    end

    always_comb begin
        fmt_next = fmt_state;
        evt_n    = evt;
        idx_n    = idx;
        pop      = 1'b0;
        o_wen    = 1'b0;
        case (ev_type)
            EV_ADDR_S:  ev_len = 4'd8;
            EV_ADDR_SR: ev_len = 4'd9;
            EV_DATA:    ev_len = 4'd5;
            default:    ev_len = 4'd3;
        endcase
        last = (idx == ev_len - 4'd1);
        if (fmt_state == F_IDLE) begin
            if (!empty && !i_wfull) begin
                pop      = 1'b1;
                evt_n    = mem[rd_ptr[AW-1:0]];
                idx_n    = 4'd0;
                fmt_next = F_EMIT;
            end
        end else if (!i_wfull) begin
            o_wen = 1'b1;
            if (!last) begin
                idx_n = idx + 4'd1;
            end else if (!empty) begin
                pop   = 1'b1;
                evt_n = mem[rd_ptr[AW-1:0]];
                idx_n = 4'd0;
            end else begin
                fmt_next = F_IDLE;
            end
        end
    end

    // Sr prefix shifts the address-line layout right by one character
    always_comb begin
        ch = 8'h20;
        j  = (ev_type == EV_ADDR_SR && idx >= 4'd2) ? idx - 4'd1 : idx;
        case (ev_type)
            EV_ADDR_S, EV_ADDR_SR: begin
                if (ev_type == EV_ADDR_SR && idx == 4'd1) ch = "r";
                else case (j)
                    4'd0: ch = "S";
                    4'd2: ch = hex(ev_byte[7:4]);
                    4'd3: ch = hex(ev_byte[3:0]);
                    4'd4: ch = ev_byte[0] ? "R" : "W";
                    4'd6: ch = ev_ack ? "N" : "A";
                    default: ch = 8'h20;
                endcase
            end
            EV_DATA: case (idx)
                4'd0: ch = hex(ev_byte[7:4]);
                4'd1: ch = hex(ev_byte[3:0]);
                4'd3: ch = ev_ack ? "N" : "A";
                default: ch = 8'h20;
            endcase
            default: case (idx)
                4'd0: ch = "P";
                4'd1: ch = 8'h0D;
                default: ch = 8'h0A;
            endcase
        endcase
    end

    assign o_wdata = (fmt_state == F_EMIT) ? ch : 8'h00;
    assign o_busy  = !empty || (fmt_state == F_EMIT);
endmodule

// File: tb/tb_i2c_stream_decoder.sv
// Directed bench: instance a uses default parameters, instance b has a 4-deep
// event FIFO and the address filter enabled for 7'h50.
module tb_i2c_stream_decoder;
    localparam int Q = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res, scl, sda, clr_ovf, wfull_a, wfull_b;
    logic       wen_a, wen_b, ovf_a, ovf_b, busy_a, busy_b;
    logic [7:0] wdata_a, wdata_b;

    i2c_stream_decoder #(.FILT_LEN(3), .EVT_DEPTH(16), .ADDR_MATCH_EN(0), .MATCH_ADDR(7'h50)) dut_a (
        .i_clk(clk), .i_res(res), .i_i2c_scl(scl), .i_i2c_sda(sda),
        .i_wfull(wfull_a), .i_clr_ovf(clr_ovf),
        .o_wen(wen_a), .o_wdata(wdata_a), .o_overflow(ovf_a), .o_busy(busy_a));

    i2c_stream_decoder #(.FILT_LEN(3), .EVT_DEPTH(4), .ADDR_MATCH_EN(1), .MATCH_ADDR(7'h50)) dut_b (
        .i_clk(clk), .i_res(res), .i_i2c_scl(scl), .i_i2c_sda(sda),
        .i_wfull(wfull_b), .i_clr_ovf(clr_ovf),
        .o_wen(wen_b), .o_wdata(wdata_b), .o_overflow(ovf_b), .o_busy(busy_b));

    logic [7:0] q_a[$], q_b[$];
    int         wcyc_b[$];
    int         cyc = 0;
    int         n_checks = 0, n_pass = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wen_a) q_a.push_back(wdata_a);
        if (wen_b) begin
            q_b.push_back(wdata_b);
            wcyc_b.push_back(cyc);
        end
    end

    function automatic string vis(input logic [7:0] q[$], input int from);
        string s = "";
        for (int i = from; i < q.size(); i++) begin
            if (q[i] == 8'h0D)      s = {s, "\\r"};
            else if (q[i] == 8'h0A) s = {s, "\\n"};
            else                    s = {s, $sformatf("%c", q[i])};
        end
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda = b;   tick(Q);
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(ack);
    endtask

    task automatic i2c_start();
        sda = 1'b0; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart();
        sda = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        sda = 1'b0; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda = 1'b0; tick(Q);
        scl = 1'b1; tick(Q);
        sda = 1'b1; tick(2 * Q);
    endtask

    task automatic wait_drain();
        int n = 0;
        tick(4);
        while ((busy_a || busy_b) && n < 2000) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (busy_a || busy_b) $display("FAIL drain_timeout busy_a=%0b busy_b=%0b", busy_a, busy_b);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [7:0] got [6];
        logic [7:0] exp [6];
        res = 1'b1; tick(3);
        got = '{7'(0) + {7'd0, wen_a}, wdata_a, {7'd0, ovf_a}, {7'd0, busy_a}, {7'd0, wen_b}, wdata_b};
        exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got[i] !== exp[i]) $display("FAIL reset_out%0d got=%h exp=%h", i, got[i], exp[i]);
            else n_pass++;
        end
        res = 1'b0; tick(10);
        n_checks++;
        if ({busy_a, busy_b, ovf_b} !== 3'b000) $display("FAIL reset_release got=%b exp=000", {busy_a, busy_b, ovf_b});
        else n_pass++;
    endtask

    task automatic test_plain_write();
        int base = q_a.size();
        string got;
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        i2c_stop();
        wait_drain();
        got = vis(q_a, base);
        n_checks++;
        if (got != "S A0W A 12 A 34 N P\\r\\n") $display("FAIL plain_write got=\"%s\" exp=\"S A0W A 12 A 34 N P\\r\\n\"", got);
        else n_pass++;
        n_checks++;
        if (ovf_a !== 1'b0) $display("FAIL plain_write_ovf got=%b exp=0", ovf_a);
        else n_pass++;
    endtask

    task automatic test_repeated_start();
        int base = q_a.size();
        string got;
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h00, 1'b0);
        i2c_rstart();
        send_byte(8'hA1, 1'b0);
        send_byte(8'h5A, 1'b1);
        i2c_stop();
        wait_drain();
        got = vis(q_a, base);
        n_checks++;
        if (got != "S A0W A 00 A Sr A1R A 5A N P\\r\\n") $display("FAIL repeated_start got=\"%s\" exp=\"S A0W A 00 A Sr A1R A 5A N P\\r\\n\"", got);
        else n_pass++;
    endtask

    // SDA low pulse of 'len' cycles with SCL high, then SDA and SCL move together
    task automatic glitch_frame(input int len);
        sda = 1'b0; tick(len);
        sda = 1'b1; scl = 1'b0; tick(Q);
        send_byte(8'hA0, 1'b0);
        i2c_stop();
        wait_drain();
    endtask

    task automatic test_glitch();
        int base = q_a.size();
        string got;
        glitch_frame(2);
        got = vis(q_a, base);
        n_checks++;
        if (got != "") $display("FAIL glitch_2cyc got=\"%s\" exp=\"\"", got);
        else n_pass++;
        base = q_a.size();
        glitch_frame(3);
        got = vis(q_a, base);
        n_checks++;
        if (got != "S A0W A P\\r\\n") $display("FAIL glitch_3cyc got=\"%s\" exp=\"S A0W A P\\r\\n\"", got);
        else n_pass++;
    endtask

    task automatic test_addr_filter();
        int base_a = q_a.size();
        int base_b = q_b.size();
        string got;
        i2c_start();
        send_byte(8'hA2, 1'b0);
        send_byte(8'h33, 1'b0);
        i2c_stop();
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h7F, 1'b0);
        i2c_stop();
        wait_drain();
        got = vis(q_b, base_b);
        n_checks++;
        if (got != "S A0W A 7F A P\\r\\n") $display("FAIL addr_filter got=\"%s\" exp=\"S A0W A 7F A P\\r\\n\"", got);
        else n_pass++;
        got = vis(q_a, base_a);
        n_checks++;
        if (got != "S A2W A 33 A P\\r\\nS A0W A 7F A P\\r\\n") $display("FAIL addr_nofilter got=\"%s\"", got);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int base = q_b.size();
        string got;
        wfull_b = 1'b1;
        i2c_start();
        send_byte(8'hA0, 1'b0);
        for (int d = 1; d <= 6; d++) send_byte(8'(d), 1'b0);
        i2c_stop();
        tick(50);
        n_checks++;
        if (ovf_b !== 1'b1) $display("FAIL ovf_set got=%b exp=1", ovf_b);
        else n_pass++;
        n_checks++;
        if (busy_b !== 1'b1) $display("FAIL ovf_busy got=%b exp=1", busy_b);
        else n_pass++;
        n_checks++;
        if (q_b.size() != base) $display("FAIL stalled_writes got=%0d exp=0", q_b.size() - base);
        else n_pass++;
        wfull_b = 1'b0; tick(16);
        wfull_b = 1'b1; tick(6);
        wfull_b = 1'b0;
        wait_drain();
        n_checks++;
        if (q_b.size() - base < 10 || wcyc_b[base + 9] - wcyc_b[base] != 9)
            $display("FAIL back_to_back got_chars=%0d exp_span=9", q_b.size() - base);
        else n_pass++;
        got = vis(q_b, base);
        n_checks++;
        if (got != "S A0W A 01 A 02 A 03 A ") $display("FAIL ovf_drain got=\"%s\" exp=\"S A0W A 01 A 02 A 03 A \"", got);
        else n_pass++;
        n_checks++;
        if (ovf_b !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", ovf_b);
        else n_pass++;
        clr_ovf = 1'b1; tick(1);
        clr_ovf = 1'b0; tick(1);
        n_checks++;
        if (ovf_b !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf_b);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        string got;
        wfull_a = 1'b1;
        i2c_start();
        send_byte(8'hA0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        n_checks++;
        if (busy_a !== 1'b1) $display("FAIL pre_reset_busy got=%b exp=1", busy_a);
        else n_pass++;
        sda = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        res = 1'b1; tick(2);
        n_checks++;
        if ({wen_a, wdata_a, ovf_a, busy_a} !== 11'h000) $display("FAIL mid_reset_out got=%h exp=000", {wen_a, wdata_a, ovf_a, busy_a});
        else n_pass++;
        res = 1'b0;
        base = q_a.size();
        wfull_a = 1'b0;
        tick(Q);
        scl = 1'b0; tick(Q);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        send_bit(1'b0);
        i2c_stop();
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h12, 1'b0);
        i2c_stop();
        wait_drain();
        got = vis(q_a, base);
        n_checks++;
        if (got != "S A0W A 12 A P\\r\\n") $display("FAIL reset_mid_frame got=\"%s\" exp=\"S A0W A 12 A P\\r\\n\"", got);
        else n_pass++;
    endtask

    initial begin
        res = 1'b1; scl = 1'b1; sda = 1'b1; clr_ovf = 1'b0;
        wfull_a = 1'b0; wfull_b = 1'b0;
        tick(2);
        test_reset();
        test_plain_write();
        test_repeated_start();
        test_glitch();
        test_addr_filter();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
